// File: rtl/ras_stack.sv
// Return-address stack: circular buffer of call link addresses with a
// single-entry checkpoint for repair after mispredicted speculative calls/returns.
module ras_stack #(
    parameter int DEPTH = 8,
    parameter int VLEN  = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [VLEN-1:0]            push_addr_i,
    input  logic                       ckpt_i,
    input  logic                       restore_i,
    output logic [VLEN-1:0]            top_o,
    output logic                       top_valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // No handshake: every cycle with a command asserted is exactly one operation,
    // and all outputs come straight from registers.
    logic [VLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   count;
    logic [PW-1:0]   s_ptr;
    logic [CW-1:0]   s_count;
    logic [VLEN-1:0] s_top;

    logic [PW-1:0] ptr_inc;
    logic [PW-1:0] ptr_dec;
    logic          is_empty;
    logic          is_full;

    assign ptr_inc  = ptr + PW'(1);
    assign ptr_dec  = ptr - PW'(1);
    assign is_empty = (count == '0);
    assign is_full  = (count == CW'(DEPTH));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            ptr     <= '0;
            count   <= '0;
            s_ptr   <= '0;
            s_count <= '0;
            s_top   <= '0;
        end else if (flush_i) begin
            // Entries stay in mem; only the bookkeeping is emptied.
            ptr     <= '0;
            count   <= '0;
            s_ptr   <= '0;
            s_count <= '0;
            s_top   <= '0;
        end else if (restore_i) begin
            ptr        <= s_ptr;
            count      <= s_count;
            mem[s_ptr] <= s_top;
        end else begin
            if (ckpt_i) begin
                s_ptr   <= ptr;
                s_count <= count;
                s_top   <= mem[ptr];
            end
            // A push+pop pair on an empty stack degenerates to a plain push.
            if (push_i && (!pop_i || is_empty)) begin
                ptr          <= ptr_inc;
                mem[ptr_inc] <= push_addr_i;
                if (!is_full) begin
                    count <= count + CW'(1);
                end
            end else if (push_i && pop_i) begin
                mem[ptr] <= push_addr_i;
            end else if (pop_i && !is_empty) begin
                ptr   <= ptr_dec;
                count <= count - CW'(1);
            end
        end
    end

    assign top_o       = mem[ptr];
    assign top_valid_o = !is_empty;
    assign count_o     = count;

endmodule

// File: tb/tb_ras_stack.sv
// Directed bench for ras_stack: reset, push/pop order, overflow, coroutine,
// checkpoint/restore, command priority and asynchronous reset.
module tb_ras_stack;

    localparam int DEPTH = 8;
    localparam int VLEN  = 64;
    localparam int CW    = $clog2(DEPTH+1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            push = 1'b0;
    logic            pop = 1'b0;
    logic [VLEN-1:0] push_addr = '0;
    logic            ckpt = 1'b0;
    logic            restore = 1'b0;
    logic [VLEN-1:0] top;
    logic            top_valid;
    logic [CW-1:0]   count;

    int checks = 0;
    int errors = 0;

    ras_stack #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push), .pop_i(pop),
        .push_addr_i(push_addr), .ckpt_i(ckpt), .restore_i(restore),
        .top_o(top), .top_valid_o(top_valid), .count_o(count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of commands, let the edge sample them, then idle the inputs.
    task automatic step(input logic f, input logic pu, input logic po,
                        input logic [VLEN-1:0] a, input logic ck, input logic rs);
        flush = f; push = pu; pop = po; push_addr = a; ckpt = ck; restore = rs;
        @(posedge clk);
        #1;
        flush = 0; push = 0; pop = 0; push_addr = '0; ckpt = 0; restore = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (top !== 64'h0) begin errors++; $display("FAIL reset_top got %h want 0", top); end
        checks++; if (top_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", top_valid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    endtask

    task automatic test_push_pop();
        logic [VLEN-1:0] exp_top [3];
        exp_top[0] = 64'h3000; exp_top[1] = 64'h2000; exp_top[2] = 64'h1000;
        step(0, 1, 0, 64'h1000, 0, 0);
        step(0, 1, 0, 64'h2000, 0, 0);
        step(0, 1, 0, 64'h3000, 0, 0);
        checks++; if (top !== 64'h3000) begin errors++; $display("FAIL pp_top got %h want 3000", top); end
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL pp_count got %0d want 3", count); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (top !== exp_top[i]) begin errors++; $display("FAIL pp_pop%0d got %h want %h", i, top, exp_top[i]); end
            step(0, 0, 1, '0, 0, 0);
        end
        checks++; if (top_valid !== 1'b0) begin errors++; $display("FAIL pp_empty_valid got %b want 0", top_valid); end
    endtask

    task automatic test_overflow();
        logic [VLEN-1:0] want;
        step(1, 0, 0, '0, 0, 0);
        for (int i = 1; i <= 9; i++) step(0, 1, 0, 64'(i * 'h100), 0, 0);
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d want 8", count); end
        for (int i = 0; i < 8; i++) begin
            want = 64'((9 - i) * 'h100);
            checks++; if (top !== want) begin errors++; $display("FAIL ovf_pop%0d got %h want %h", i, top, want); end
            step(0, 0, 1, '0, 0, 0);
        end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL ovf_drained got %0d want 0", count); end
        step(0, 0, 1, '0, 0, 0);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL ovf_extra_pop got %0d want 0", count); end
        checks++; if (top_valid !== 1'b0) begin errors++; $display("FAIL ovf_valid got %b want 0", top_valid); end
    endtask

    task automatic test_coroutine();
        step(1, 0, 0, '0, 0, 0);
        step(0, 1, 0, 64'h90, 0, 0);
        step(0, 1, 0, 64'hA0, 0, 0);
        step(0, 1, 1, 64'hB0, 0, 0);
        checks++; if (top !== 64'hB0) begin errors++; $display("FAIL co_top got %h want b0", top); end
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL co_count got %0d want 2", count); end
        step(0, 0, 1, '0, 0, 0);
        checks++; if (top !== 64'h90) begin errors++; $display("FAIL co_below got %h want 90", top); end
        step(1, 0, 0, '0, 0, 0);
        step(0, 1, 1, 64'hB0, 0, 0);
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL co_empty_count got %0d want 1", count); end
        checks++; if (top !== 64'hB0) begin errors++; $display("FAIL co_empty_top got %h want b0", top); end
    endtask

    task automatic test_ckpt_restore();
        step(1, 0, 0, '0, 0, 0);
        step(0, 1, 0, 64'h10, 0, 0);
        step(0, 1, 0, 64'h20, 0, 0);
        step(0, 1, 0, 64'h30, 1, 0);
        checks++; if (top !== 64'h30 || count !== 4'd3) begin errors++; $display("FAIL ck_push got %h/%0d want 30/3", top, count); end
        step(0, 0, 1, '0, 0, 0);
        step(0, 1, 0, 64'h40, 0, 0);
        checks++; if (top !== 64'h40 || count !== 4'd3) begin errors++; $display("FAIL ck_spec got %h/%0d want 40/3", top, count); end
        step(0, 0, 0, '0, 0, 1);
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL ck_restore_count got %0d want 2", count); end
        checks++; if (top !== 64'h20) begin errors++; $display("FAIL ck_restore_top got %h want 20", top); end
        step(0, 0, 1, '0, 0, 0);
        checks++; if (top !== 64'h10 || count !== 4'd1) begin errors++; $display("FAIL ck_pop got %h/%0d want 10/1", top, count); end
    endtask

    task automatic test_priority();
        step(1, 0, 0, '0, 0, 0);
        step(0, 1, 0, 64'h10, 0, 0);
        step(0, 1, 0, 64'h20, 0, 0);
        step(0, 0, 0, '0, 1, 0);
        step(0, 1, 0, 64'h55, 0, 1);
        checks++; if (top !== 64'h20 || count !== 4'd2) begin errors++; $display("FAIL pri_restore_push got %h/%0d want 20/2", top, count); end
        step(1, 1, 0, 64'h66, 0, 0);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL pri_flush_push got %0d want 0", count); end
        step(0, 1, 0, 64'h77, 1, 0);
        step(1, 0, 0, '0, 0, 1);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL pri_flush_restore got %0d want 0", count); end
        step(0, 0, 0, '0, 0, 1);
        checks++; if (count !== 4'd0 || top_valid !== 1'b0) begin errors++; $display("FAIL pri_restore_cleared got %0d/%b want 0/0", count, top_valid); end
        checks++; if (top !== 64'h0) begin errors++; $display("FAIL pri_restore_top got %h want 0", top); end
    endtask

    task automatic test_async_reset();
        step(1, 0, 0, '0, 0, 0);
        for (int i = 1; i <= 5; i++) step(0, 1, 0, 64'(i * 'h11), 0, 0);
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL ar_pre_count got %0d want 5", count); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (top_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL ar_immediate got %b/%0d want 0/0", top_valid, count); end
        checks++; if (top !== 64'h0) begin errors++; $display("FAIL ar_top got %h want 0", top); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 1, 0, 64'h77, 0, 0);
        checks++; if (top !== 64'h77 || count !== 4'd1) begin errors++; $display("FAIL ar_after got %h/%0d want 77/1", top, count); end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_coroutine();
        test_ckpt_restore();
        test_priority();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
